// File: rtl/vote_ctrl.sv
// vote_ctrl: sequencing controller for the voting display's 7-segment decoder.
// Runs a power-up lamp test, blanks while idle, tallies one ballot per voter
// during a timed window, then holds the final count and a majority flag.
module vote_ctrl #(
  parameter int N_VOTERS    = 8,
  parameter int LT_CYCLES   = 4,
  parameter int WIN_CYCLES  = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                n_CR,
  input  logic                start,
  input  logic [N_VOTERS-1:0] vote,
  output logic                n_T,
  output logic                n_M,
  output logic [3:0]          X,
  output logic                busy,
  output logic                pass
);

  typedef enum logic [1:0] {
    S_LAMP = 2'd0,
    S_IDLE = 2'd1,
    S_VOTE = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // One shared timer serves all timed states, so it is sized for the longest.
  localparam int T1   = (LT_CYCLES > WIN_CYCLES) ? LT_CYCLES : WIN_CYCLES;
  localparam int TMAX = (T1 > HOLD_CYCLES) ? T1 : HOLD_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] LT_LAST   = TW'(LT_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST  = TW'(WIN_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  state_t              state;
  logic [TW-1:0]       timer;
  logic [N_VOTERS-1:0] ballot;
  logic [N_VOTERS-1:0] vote_q;
  logic [N_VOTERS-1:0] rise;
  logic [N_VOTERS-1:0] ballot_nxt;

  // Number of set ballots; N_VOTERS <= 8 keeps this within 4 bits.
  function automatic logic [3:0] popcount(input logic [N_VOTERS-1:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) c = c + {3'b000, b[i]};
    return c;
  endfunction

  // Decoder digit code; the table is a reflected code, not plain binary.
  function automatic logic [3:0] encode(input logic [3:0] n);
    logic [3:0] code;
    case (n)
      4'd0:    code = 4'b0000;
      4'd1:    code = 4'b0001;
      4'd2:    code = 4'b0011;
      4'd3:    code = 4'b0010;
      4'd4:    code = 4'b0110;
      4'd5:    code = 4'b0111;
      4'd6:    code = 4'b0101;
      4'd7:    code = 4'b0100;
      4'd8:    code = 4'b1100;
      default: code = 4'b1000;
    endcase
    return code;
  endfunction

  // Strict majority: a tie fails.
  function automatic logic majority(input logic [3:0] c);
    return (5'(c) << 1) > 5'(N_VOTERS);
  endfunction

  // Rising edges on voter buttons only register while the window is open.
  always_comb begin
    rise       = vote & ~vote_q;
    ballot_nxt = ballot;
    if (state == S_VOTE) ballot_nxt = ballot | rise;
  end

  // Previous-cycle copy of the buttons for edge detection, in every state.
  always_ff @(posedge CLK or negedge n_CR) begin
    if (!n_CR) vote_q <= '0;
    else       vote_q <= vote;
  end

  // Main sequencer: state, timer, ballots and all registered decoder outputs.
  always_ff @(posedge CLK or negedge n_CR) begin
    if (!n_CR) begin
      state  <= S_LAMP;
      timer  <= '0;
      ballot <= '0;
      n_T    <= 1'b0;
      n_M    <= 1'b1;
      X      <= 4'b0000;
      busy   <= 1'b1;
      pass   <= 1'b0;
    end else begin
      case (state)
        S_LAMP: begin
          if (timer == LT_LAST) begin
            state <= S_IDLE;
            timer <= '0;
            n_T   <= 1'b1;
            n_M   <= 1'b0;
            X     <= 4'b0000;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_IDLE: begin
          if (start) begin
            state  <= S_VOTE;
            timer  <= '0;
            ballot <= '0;
            n_T    <= 1'b1;
            n_M    <= 1'b1;
            X      <= 4'b0000;
            busy   <= 1'b1;
            pass   <= 1'b0;
          end
        end
        S_VOTE: begin
          ballot <= ballot_nxt;
          if (timer == WIN_LAST) begin
            // A press on the final window edge must already show in SHOW.
            state <= S_SHOW;
            timer <= '0;
            X     <= encode(popcount(ballot_nxt));
            pass  <= majority(popcount(ballot_nxt));
          end else begin
            timer <= timer + 1'b1;
            X     <= encode(popcount(ballot));
          end
        end
        S_SHOW: begin
          if (timer == HOLD_LAST) begin
            state <= S_IDLE;
            timer <= '0;
            n_M   <= 1'b0;
            X     <= 4'b0000;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
            X     <= encode(popcount(ballot));
            pass  <= majority(popcount(ballot));
          end
        end
        default: begin
          state <= S_LAMP;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
